ddr_rd_arbiter: RTL
===================

Name: ddr_rd_arbiter

Overview:
- Round-robin arbiter that shares the single DDR burst-read channel among NUM_REQ read clients (conv weight loader, image loader, spike/feature fetch).
- Sits between the clients and the DDR burst-read user interface.
- Holds one outstanding burst at a time and routes the returned beats and finish to the granted client.
- Checks the returned beat count against the requested length.

Parameters:
- NUM_REQ, 3: number of read requesters (2..8).
- DATA_W, 64: data beat width in bits.
- ADDR_W, 32: byte-address width.
- LEN_W, 12: burst length width, in beats.

Ports:
- user_clk  in  1  clock.
- user_rst  in  1  synchronous, active-high reset.
- cli_req  in  NUM_REQ  per-client read request, level; held until cli_ack.
- cli_addr  in  NUM_REQ*ADDR_W  packed byte addresses; client i occupies bits [i*ADDR_W +: ADDR_W].
- cli_len  in  NUM_REQ*LEN_W  packed beat counts, same packing.
- cli_ack  out  NUM_REQ  one-cycle pulse: request accepted, addr/len captured.
- cli_rdata  out  DATA_W  read data, broadcast to all clients.
- cli_rvalid  out  NUM_REQ  one-hot beat-valid for the granted client.
- cli_finish  out  NUM_REQ  one-cycle burst-complete pulse for the granted client.
- burst_read_addr  out  ADDR_W  byte address to DDR.
- burst_read_len  out  LEN_W  beat count to DDR.
- burst_read_req  out  1  one-cycle request pulse to DDR.
- burst_read_data  in  DATA_W  DDR read data.
- burst_read_valid  in  1  DDR beat valid.
- burst_read_finish  in  1  DDR burst-done pulse.
- busy  out  1  high whenever the state is not IDLE.
- len_err  out  1  sticky: a burst finished with a beat count different from its requested length.

Behaviour:
- Reset (synchronous, user_rst=1 at a clock edge):
  - All outputs go to 0, including len_err.
  - State goes to IDLE, RR pointer to 0, beat counter to 0.
  - Reset mid-burst abandons the transfer. No finish is issued. DDR-side activity is ignored until the next grant.
- States:
  - IDLE -> ISSUE -> DATA -> DONE -> IDLE.
- IDLE:
  - If any cli_req is high, select the first requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - Register grant index g, and capture cli_addr[g] and cli_len[g] into burst_read_addr and burst_read_len.
  - Go to ISSUE.
  - Unrequested clients are never granted.
- ISSUE (exactly 1 cycle):
  - burst_read_req=1 and cli_ack[g]=1.
  - Clear the beat counter.
  - Set the RR pointer to (g+1) mod NUM_REQ.
  - Go to DATA.
  - Latency: req seen in IDLE at edge N gives ack/burst_read_req high in cycle N+1.
- DATA:
  - Each burst_read_valid beat: cli_rdata <= burst_read_data and cli_rvalid[g] <= 1, one registered cycle later; other cli_rvalid bits stay 0.
  - The beat counter increments on each beat, saturating at all-ones.
  - On burst_read_finish, go to DONE.
  - A valid beat in the same cycle as finish is still forwarded and counted.
- DONE (1 cycle):
  - cli_finish[g]=1.
  - Set len_err if beat count != captured len.
  - Return to IDLE.
  - Finish therefore follows the last cli_rvalid by at least one cycle.
- burst_read_addr/len stay stable from ISSUE until IDLE next captures.
- Zero-length request:
  - Issued normally; DDR returns finish with no beats.
  - cli_finish pulses and len_err stays 0.
- Minimum gap between consecutive grants is 1 IDLE cycle. Back-to-back throughput for a len=L burst is L plus DDR overhead plus 3 cycles.
- Client withdraws req before ack: legal, and it is not granted. A req dropped during the IDLE capture cycle is still granted, so clients must hold req until ack.
- burst_read_valid or burst_read_finish arriving in IDLE, ISSUE or DONE is ignored. len_err is not set by these.
- No data buffering: clients must accept one beat per cycle while their burst is granted.

Test Plan:
- Single client 0, addr=0x1000, len=4 -> burst_read_req pulses 1 cycle after req with addr=0x1000, len=4. cli_ack[0] rises in the same cycle. 4 cli_rvalid[0] beats carry mem[0x200..0x203]. cli_finish[0] follows by at least 1 cycle. len_err=0.
- Clients 0, 1 and 2 request simultaneously, len=2 each -> grant order 0,1,2. The next round with all three requesting again starts at 0. No cli_rvalid is seen on ungranted clients.
- Client 2 requests continuously while client 1 raises req mid-burst -> after client 2 finishes, client 1 is granted before client 2 again.
- len=0 request -> burst_read_req issued. Zero cli_rvalid pulses, cli_finish pulses once, len_err stays 0.
- DDR stub returns 3 beats for len=4 -> cli_finish still pulses and len_err latches 1 until user_rst.
- user_rst asserted after 2 of 8 beats -> the next cycle has all outputs 0 and busy=0 with no cli_finish. A new request after reset is granted to the lowest-index requester.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR burst-read channel among NUM_REQ clients.
// One burst in flight; beats and finish are routed to the granted client, beat count checked.
module ddr_rd_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 12
) (
  input  logic                      user_clk,
  input  logic                      user_rst,
  input  logic [NUM_REQ-1:0]        cli_req,
  input  logic [NUM_REQ*ADDR_W-1:0] cli_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  cli_len,
  output logic [NUM_REQ-1:0]        cli_ack,
  output logic [DATA_W-1:0]         cli_rdata,
  output logic [NUM_REQ-1:0]        cli_rvalid,
  output logic [NUM_REQ-1:0]        cli_finish,
  output logic [ADDR_W-1:0]         burst_read_addr,
  output logic [LEN_W-1:0]          burst_read_len,
  output logic                      burst_read_req,
  input  logic [DATA_W-1:0]         burst_read_data,
  input  logic                      burst_read_valid,
  input  logic                      burst_read_finish,
  output logic                      busy,
  output logic                      len_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant;
  logic [IDX_W-1:0]     pick;
  logic                 pick_vld;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [ADDR_W-1:0]    pick_addr;
  logic [LEN_W-1:0]     pick_len;
  logic [LEN_W-1:0]     beat_cnt;
  logic                 beat;

  assign beat = (state == DATA) && burst_read_valid;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned j;
    pick_vld = 1'b0;
    pick     = rr_ptr;
    j        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && cli_req[IDX_W'(j)]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(j);
      end
    end
  end

  // Select the picked client's address/length and build one-hot vectors
  always_comb begin
    pick_addr = '0;
    pick_len  = '0;
    pick_oh   = '0;
    grant_oh  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_addr  = cli_addr[i*ADDR_W +: ADDR_W];
        pick_len   = cli_len[i*LEN_W +: LEN_W];
        pick_oh[i] = 1'b1;
      end
      if (grant == IDX_W'(i)) grant_oh[i] = 1'b1;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = ISSUE;
      ISSUE:   state_nx = DATA;
      DATA:    if (burst_read_finish) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs and datapath; finish lands the cycle after DONE so it trails the last beat
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      cli_ack         <= '0;
      cli_rdata       <= '0;
      cli_rvalid      <= '0;
      cli_finish      <= '0;
      burst_read_addr <= '0;
      burst_read_len  <= '0;
      burst_read_req  <= 1'b0;
      busy            <= 1'b0;
      len_err         <= 1'b0;
      rr_ptr          <= '0;
      grant           <= '0;
      beat_cnt        <= '0;
    end else begin
      burst_read_req <= (state_nx == ISSUE);
      cli_ack        <= (state_nx == ISSUE) ? pick_oh : '0;
      busy           <= (state_nx != IDLE);
      cli_rvalid     <= beat ? grant_oh : '0;
      cli_finish     <= (state == DONE) ? grant_oh : '0;
      if (beat) cli_rdata <= burst_read_data;

      if (state == IDLE && pick_vld) begin
        grant           <= pick;
        burst_read_addr <= pick_addr;
        burst_read_len  <= pick_len;
      end

      if (state == ISSUE) begin
        beat_cnt <= '0;
        rr_ptr   <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
      end else if (beat && beat_cnt != '1) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end

      if (state == DONE && beat_cnt != burst_read_len) len_err <= 1'b1;
    end
  end

endmodule
